// File: rtl/level_pacer.sv
// Speed-to-strobe pacing for every actor plus the frightened-mode timer.
// All state is registered; outputs change only on the rising clock edge.
module level_pacer #(
   parameter int NUM_CH        = 5,
   parameter int SPEED_W       = 8,
   parameter int STEP_DEN      = 200,
   parameter int TICKS_PER_SEC = 60,
   parameter int FLASH_TICKS   = 28
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      tick,
   input  logic                      clear_acc,
   input  logic [NUM_CH-1:0]         ch_en,
   input  logic [NUM_CH*SPEED_W-1:0] speed_bus,
   input  logic                      fright_start,
   input  logic [3:0]                fright_time,
   input  logic [2:0]                fright_flashes,
   output logic [NUM_CH-1:0]         move_stb,
   output logic                      fright_active,
   output logic                      fright_white,
   output logic                      fright_done
);

   localparam int ACC_W  = $clog2(2*STEP_DEN+1);
   localparam int SUM_W  = ((ACC_W > SPEED_W) ? ACC_W : SPEED_W) + 1;
   localparam int CNT_W  = $clog2(15*TICKS_PER_SEC+1);
   localparam int FL_W   = $clog2(7*FLASH_TICKS+1);
   localparam int CMP_W  = (CNT_W > FL_W) ? CNT_W : FL_W;
   localparam int HALF   = FLASH_TICKS/2;
   localparam int HALF_W = $clog2(HALF+1);

   localparam logic [SUM_W-1:0]  DEN       = SUM_W'(STEP_DEN);
   localparam logic [HALF_W-1:0] HALF_LOAD = HALF_W'(HALF);

   // ------------------------------------------------------------------
   // Movement accumulators
   // ------------------------------------------------------------------
   logic [ACC_W-1:0]  acc     [NUM_CH];
   logic [ACC_W-1:0]  acc_nxt [NUM_CH];
   logic [SUM_W-1:0]  spd     [NUM_CH];
   logic [SUM_W-1:0]  sum     [NUM_CH];
   logic [NUM_CH-1:0] stb_nxt;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      stb_nxt = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         spd[c]     = SUM_W'(speed_bus[c*SPEED_W +: SPEED_W]);
         sum[c]     = SUM_W'(acc[c]) + spd[c];
         acc_nxt[c] = acc[c];
         if (clear_acc) begin
            acc_nxt[c] = '0;
         end else if (tick && ch_en[c]) begin
            // Speeds at or above the threshold strobe every tick without touching the phase.
            if (spd[c] >= DEN) begin
               stb_nxt[c] = 1'b1;
            end else if (sum[c] >= DEN) begin
               stb_nxt[c] = 1'b1;
               acc_nxt[c] = ACC_W'(sum[c] - DEN);
            end else begin
               acc_nxt[c] = ACC_W'(sum[c]);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: the accumulators are a handful of flops, not a RAM, so each one is reset explicitly.
         for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
         move_stb <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         for (int c = 0; c < NUM_CH; c++) acc[c] <= acc_nxt[c];
         move_stb <= stb_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Frightened-mode timer
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {IDLE, BLUE, FLASH} fright_state_e;

   fright_state_e     state;
   logic [CMP_W-1:0]  remain;
   logic [CMP_W-1:0]  flash_len;
   logic [HALF_W-1:0] half_cnt;
   logic [CMP_W-1:0]  start_t;
   logic [CMP_W-1:0]  start_f;
   logic [CMP_W-1:0]  remain_dec;
   logic              start_ok;

   assign start_t    = CMP_W'(fright_time) * CMP_W'(TICKS_PER_SEC);
   assign start_f    = CMP_W'(fright_flashes) * CMP_W'(FLASH_TICKS);
   assign remain_dec = remain - CMP_W'(1);
   assign start_ok   = fright_start && (fright_time != 4'd0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         remain        <= '0;
         flash_len     <= '0;
         half_cnt      <= '0;
         fright_active <= 1'b0;
         fright_white  <= 1'b0;
         fright_done   <= 1'b0;
      end else begin
         fright_done <= 1'b0;
         // A valid start (also a restart) takes priority and swallows a coincident tick.
         if (start_ok) begin
            remain        <= start_t;
            flash_len     <= start_f;
            fright_active <= 1'b1;
            if (start_f >= start_t) begin
               state        <= FLASH;
               fright_white <= 1'b1;
               half_cnt     <= HALF_LOAD;
            end else begin
               state        <= BLUE;
               fright_white <= 1'b0;
            end
         end else if (tick) begin
            case (state)
               BLUE: begin
                  remain <= remain_dec;
                  if (remain_dec == '0) begin
                     state         <= IDLE;
                     fright_active <= 1'b0;
                     fright_white  <= 1'b0;
                     fright_done   <= 1'b1;
                  end else if (remain_dec == flash_len) begin
                     state        <= FLASH;
                     fright_white <= 1'b1;
                     half_cnt     <= HALF_LOAD;
                  end
               end
               FLASH: begin
                  remain <= remain_dec;
                  if (remain_dec == '0) begin
                     state         <= IDLE;
                     fright_active <= 1'b0;
                     fright_white  <= 1'b0;
                     fright_done   <= 1'b1;
                  end else if (half_cnt == HALF_W'(1)) begin
                     fright_white <= ~fright_white;
                     half_cnt     <= HALF_LOAD;
                  end else begin
                     half_cnt <= half_cnt - HALF_W'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_level_pacer.sv
// Bench for level_pacer: a tick-count reference model checked every cycle,
// plus directed scenarios pinned with hand-computed numbers.
module tb_level_pacer;

   localparam int NUM_CH      = 5;
   localparam int SPEED_W     = 8;
   localparam int STEP_DEN    = 200;
   localparam int TPS         = 60;
   localparam int FLASH_TICKS = 28;
   localparam int HALF        = FLASH_TICKS/2;

   logic                      clk = 1'b0;
   logic                      rst_n = 1'b0;
   logic                      tick = 1'b0;
   logic                      clear_acc = 1'b0;
   logic [NUM_CH-1:0]         ch_en = '1;
   logic [NUM_CH*SPEED_W-1:0] speed_bus = '0;
   logic                      fright_start = 1'b0;
   logic [3:0]                fright_time = '0;
   logic [2:0]                fright_flashes = '0;
   logic [NUM_CH-1:0]         move_stb;
   logic                      fright_active;
   logic                      fright_white;
   logic                      fright_done;

   level_pacer #(
      .NUM_CH(NUM_CH), .SPEED_W(SPEED_W), .STEP_DEN(STEP_DEN),
      .TICKS_PER_SEC(TPS), .FLASH_TICKS(FLASH_TICKS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .clear_acc(clear_acc),
      .ch_en(ch_en), .speed_bus(speed_bus), .fright_start(fright_start),
      .fright_time(fright_time), .fright_flashes(fright_flashes),
      .move_stb(move_stb), .fright_active(fright_active),
      .fright_white(fright_white), .fright_done(fright_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: accumulator arithmetic and fright timing expressed as
   // elapsed ticks since the last valid start.
   int               m_acc [NUM_CH];
   logic [NUM_CH-1:0] m_stb = '0;
   bit               m_on = 0;
   bit               m_done = 0;
   int               m_t = 0, m_f = 0, m_k = 0;
   int               tick_no = 0;
   bit               started = 0;

   function automatic int spd(input int c);
      return int'(speed_bus[c*SPEED_W +: SPEED_W]);
   endfunction

   function automatic bit m_white();
      int flash_start;
      if (!m_on) return 1'b0;
      if (m_t - m_k > m_f) return 1'b0;
      flash_start = (m_t > m_f) ? m_t - m_f : 0;
      return (((m_k - flash_start) / HALF) % 2) == 0;
   endfunction

   always @(posedge clk) begin
      started = 1;
      if (!rst_n) begin
         foreach (m_acc[c]) m_acc[c] = 0;
         m_stb  = '0;
         m_on   = 0;
         m_done = 0;
         m_t = 0; m_f = 0; m_k = 0;
      end else begin
         m_stb = '0;
         if (tick) tick_no++;
         for (int c = 0; c < NUM_CH; c++) begin
            if (clear_acc) m_acc[c] = 0;
            else if (tick && ch_en[c]) begin
               if (spd(c) >= STEP_DEN) m_stb[c] = 1'b1;
               else if (m_acc[c] + spd(c) >= STEP_DEN) begin
                  m_stb[c] = 1'b1;
                  m_acc[c] = m_acc[c] + spd(c) - STEP_DEN;
               end else m_acc[c] = m_acc[c] + spd(c);
            end
         end
         m_done = 0;
         if (fright_start && fright_time != 0) begin
            m_on = 1;
            m_t  = int'(fright_time) * TPS;
            m_f  = int'(fright_flashes) * FLASH_TICKS;
            m_k  = 0;
         end else if (tick && m_on) begin
            m_k++;
            if (m_k == m_t) begin
               m_on   = 0;
               m_done = 1;
            end
         end
      end
   end

   // Observation counters used only with literal expectations.
   int          stb_cnt [NUM_CH];
   logic [31:0] mask = '0;
   int          base = 0;
   int          done_cnt = 0;
   int          act_ticks = 0, wh_ticks = 0, first_white = 0;

   always @(negedge clk) begin
      if (started) begin
         check("move_stb", move_stb, m_stb);
         check("fright_active", fright_active, m_on);
         check("fright_white", fright_white, m_white());
         check("fright_done", fright_done, m_done);
         for (int c = 0; c < NUM_CH; c++) if (move_stb[c]) stb_cnt[c]++;
         if (move_stb[0] && (tick_no - base) >= 0 && (tick_no - base) < 32)
            mask[tick_no - base] = 1'b1;
         if (fright_done) done_cnt++;
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic clr_counters();
      base = tick_no;
      mask = '0;
      foreach (stb_cnt[c]) stb_cnt[c] = 0;
      act_ticks = 0;
      wh_ticks = 0;
      first_white = 0;
   endtask

   task automatic pulse_tick();
      if (fright_active) act_ticks++;
      if (fright_white) begin
         wh_ticks++;
         if (first_white == 0) first_white = tick_no - base + 1;
      end
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
   endtask

   task automatic set_speed(input int c, input int v);
      speed_bus[c*SPEED_W +: SPEED_W] = SPEED_W'(v);
   endtask

   task automatic clear_pulse();
      clear_acc = 1'b1;
      step();
      clear_acc = 1'b0;
      clr_counters();
   endtask

   task automatic start_fright(input int t, input int fl);
      fright_time    = 4'(t);
      fright_flashes = 3'(fl);
      fright_start   = 1'b1;
      step();
      fright_start   = 1'b0;
   endtask

   task automatic run_to_done(output int n);
      int d0;
      d0 = done_cnt;
      n = 0;
      while (done_cnt == d0 && n < 1000) begin
         pulse_tick();
         n++;
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n, d0;
      foreach (stb_cnt[c]) stb_cnt[c] = 0;

      rst_n = 1'b0;
      repeat (3) step();
      check("reset move_stb", move_stb, 0);
      check("reset fright_active", fright_active, 0);
      check("reset fright_white", fright_white, 0);
      check("reset fright_done", fright_done, 0);
      rst_n = 1'b1;
      step();

      // Speed 80: strobes after ticks 3, 5, 8, 10.
      ch_en = '1;
      for (int c = 0; c < NUM_CH; c++) set_speed(c, 80);
      clear_pulse();
      repeat (10) pulse_tick();
      check("spd80 count", stb_cnt[0], 4);
      check("spd80 tick mask", mask, 32'd1320);
      check("spd80 model acc", m_acc[0], 0);

      // Speed 75: strobes after ticks 3, 6, 8.
      for (int c = 0; c < NUM_CH; c++) set_speed(c, 75);
      clear_pulse();
      repeat (8) pulse_tick();
      check("spd75 count", stb_cnt[0], 3);
      check("spd75 tick mask", mask, 32'd328);

      // Saturated, zero, disabled, 80 and 100 side by side.
      set_speed(0, 210); set_speed(1, 0); set_speed(2, 80); set_speed(3, 80); set_speed(4, 100);
      ch_en = 5'b11011;
      clear_pulse();
      repeat (6) pulse_tick();
      check("spd210 count", stb_cnt[0], 6);
      check("spd0 count", stb_cnt[1], 0);
      check("disabled count", stb_cnt[2], 0);
      check("spd80 6-tick count", stb_cnt[3], 2);
      check("spd100 count", stb_cnt[4], 3);

      // Clear coincident with tick: clear wins, no strobe.
      ch_en = '1;
      for (int c = 0; c < NUM_CH; c++) set_speed(c, 210);
      clear_acc = 1'b1; tick = 1'b1;
      step();
      clear_acc = 1'b0; tick = 1'b0;
      check("clear+tick no strobe", move_stb, 0);
      step();

      // Randomized accumulator traffic, including mid-interval speed changes.
      repeat (400) begin
         for (int c = 0; c < NUM_CH; c++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) set_speed(c, 0);
            else if (r == 1) set_speed(c, $urandom_range(200, 255));
            else set_speed(c, $urandom_range(1, 199));
         end
         ch_en     = NUM_CH'($urandom);
         clear_acc = ($urandom_range(0, 15) == 0);
         tick      = $urandom_range(0, 1) == 1;
         step();
      end
      tick = 1'b0; clear_acc = 1'b0;
      step();

      // Six seconds, five flashes: 220 blue + 140 flashing ticks.
      start_fright(6, 5);
      clr_counters();
      d0 = done_cnt;
      run_to_done(n);
      check("f6 active ticks", act_ticks, 360);
      check("f6 white ticks", wh_ticks, 70);
      check("f6 first white tick", first_white, 221);
      step(); step();
      check("f6 done pulses", done_cnt - d0, 1);

      // One second, three flashes: flashing from the start.
      start_fright(1, 3);
      clr_counters();
      d0 = done_cnt;
      run_to_done(n);
      check("f1 active ticks", act_ticks, 60);
      check("f1 white ticks", wh_ticks, 32);
      check("f1 first white tick", first_white, 1);
      check("f1 done pulses", done_cnt - d0, 1);

      // Zero fright time is ignored.
      start_fright(0, 5);
      clr_counters();
      repeat (5) pulse_tick();
      check("f0 active", fright_active, 0);
      check("f0 active ticks", act_ticks, 0);

      // Restart at tick 300 reloads the full 360 ticks back in blue.
      d0 = done_cnt;
      start_fright(6, 5);
      repeat (300) pulse_tick();
      start_fright(6, 5);
      check("restart active", fright_active, 1);
      check("restart no done", done_cnt - d0, 0);
      clr_counters();
      run_to_done(n);
      check("restart active ticks", act_ticks, 360);
      check("restart first white", first_white, 221);
      check("restart done pulses", done_cnt - d0, 1);

      // Start coincident with tick: that tick does not count.
      fright_time = 4'd1; fright_flashes = 3'd0;
      fright_start = 1'b1; tick = 1'b1;
      step();
      fright_start = 1'b0; tick = 1'b0;
      step();
      clr_counters();
      run_to_done(n);
      check("start+tick active ticks", act_ticks, 60);
      check("start+tick white ticks", wh_ticks, 0);

      // Reset mid-flash: everything clears, no done pulse.
      start_fright(1, 3);
      repeat (10) pulse_tick();
      d0 = done_cnt;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("rst mid-flash active", fright_active, 0);
      check("rst mid-flash white", fright_white, 0);
      check("rst mid-flash done", fright_done, 0);
      check("rst mid-flash move_stb", move_stb, 0);
      step(); step();
      check("rst mid-flash no done", done_cnt - d0, 0);

      // Randomized fright and movement traffic, including restarts.
      repeat (3000) begin
         tick           = ($urandom_range(0, 2) == 0);
         fright_start   = ($urandom_range(0, 299) == 0);
         fright_time    = 4'($urandom_range(0, 3));
         fright_flashes = 3'($urandom);
         clear_acc      = ($urandom_range(0, 63) == 0);
         if ($urandom_range(0, 7) == 0) set_speed($urandom_range(0, NUM_CH-1), $urandom_range(0, 255));
         step();
      end
      tick = 1'b0; fright_start = 1'b0; clear_acc = 1'b0;
      step(); step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
